// File: rtl/ac_link_rotate_if.sv
// Bus/handshake bundle for the PDP-8 AC/Link stage: adder result in, AC/L and the
// operate-sequence START/BUSY/DONE handshake out, plus the FSM state for observation.
interface ac_link_rotate_if;
  logic [11:0] BUS;
  logic        CO;
  logic        LD_AC;
  logic        CY_TOG;
  logic        START;
  logic [7:0]  OPR;
  logic [11:0] AC;
  logic        LINK;
  logic        AC_ZERO;
  logic        AC_NEG;
  logic        BUSY;
  logic        DONE;
  logic [2:0]  state_dbg;

  // START is taken only in a cycle with BUSY=0 and LD_AC=0. BUSY stays high until the
  // sequence ends. DONE pulses for one cycle with BUSY=0, and a new START may be issued then.
  modport master (
    output BUS, CO, LD_AC, CY_TOG, START, OPR,
    input  AC, LINK, AC_ZERO, AC_NEG, BUSY, DONE, state_dbg
  );

  modport slave (
    input  BUS, CO, LD_AC, CY_TOG, START, OPR,
    output AC, LINK, AC_ZERO, AC_NEG, BUSY, DONE, state_dbg
  );
endinterface

// File: rtl/ac_link_rotate.sv
// PDP-8 AC/Link register stage with group-1 operate sequencer (CLR, CMP, IAC, ROT1, ROT2).
// Define OPR_BSW_EN to implement BSW (byte swap) when TWO is set without RAR/RAL.
module ac_link_rotate (
  input logic             CLK,
  input logic             RESET,
  ac_link_rotate_if.slave io
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_CMP  = 3'd2,
    S_IAC  = 3'd3,
    S_ROT1 = 3'd4,
    S_ROT2 = 3'd5
  } state_t;

  state_t      state;
  logic [11:0] ac;
  logic        link;
  logic [7:0]  opr_q;
  logic        busy;
  logic        done;

  logic        op_cla, op_cll, op_cma, op_cml, op_rar, op_ral, op_two, op_iac;
  logic        rot_second;
  logic [11:0] rot_ac;
  logic        rot_l;

  assign op_cla = opr_q[7];
  assign op_cll = opr_q[6];
  assign op_cma = opr_q[5];
  assign op_cml = opr_q[4];
  assign op_rar = opr_q[3];
  assign op_ral = opr_q[2];
  assign op_two = opr_q[1];
  assign op_iac = opr_q[0];

  // A second rotate only happens when exactly one direction is selected.
  assign rot_second = op_two & (op_rar ^ op_ral);

  always_comb begin
    rot_ac = ac;
    rot_l  = link;
    if (op_ral && !op_rar) begin
      rot_l  = ac[11];
      rot_ac = {ac[10:0], link};
    end else if (op_rar && !op_ral) begin
      rot_l  = ac[0];
      rot_ac = {link, ac[11:1]};
    end
`ifdef OPR_BSW_EN
    else if (op_two && !op_rar && !op_ral) begin
      rot_ac = {ac[5:0], ac[11:6]};
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      ac    <= 12'd0;
      link  <= 1'b0;
      opr_q <= 8'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A load in the same cycle as START takes priority and drops the START.
          if (io.LD_AC) begin
            ac <= io.BUS;
            if (io.CY_TOG && io.CO) link <= ~link;
          end else if (io.START) begin
            opr_q <= io.OPR;
            state <= S_CLR;
            busy  <= 1'b1;
          end
        end
        S_CLR: begin
          if (op_cla) ac <= 12'd0;
          if (op_cll) link <= 1'b0;
          state <= S_CMP;
        end
        S_CMP: begin
          if (op_cma) ac <= ~ac;
          if (op_cml) link <= ~link;
          state <= S_IAC;
        end
        S_IAC: begin
          if (op_iac) {link, ac} <= {link, ac} + 13'd1;
          state <= S_ROT1;
        end
        S_ROT1: begin
          ac   <= rot_ac;
          link <= rot_l;
          if (rot_second) begin
            state <= S_ROT2;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_ROT2: begin
          ac    <= rot_ac;
          link  <= rot_l;
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io.AC        = ac;
  assign io.LINK      = link;
  assign io.AC_ZERO   = (ac == 12'd0);
  assign io.AC_NEG    = ac[11];
  assign io.BUSY      = busy;
  assign io.DONE      = done;
  assign io.state_dbg = state;
endmodule
